i3c_cpuif_queue_port: RTL and testbench



---
 rtl/i3c_cpuif_queue_port.sv | 216 +++++++++++++++++++++
 tb/tb_i3c_cpuif_queue_port.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i3c_cpuif_queue_port.sv
// i3c_cpuif_queue_port
// CPU-interface splitter placed after the AHB-Lite-to-CSR bridge. Two addresses
// are terminated locally: a write-only command port feeding a command FIFO and a
// read-only response port draining a response FIFO. Every other address is
// forwarded unchanged to the register block on m_cpuif_*.
// Optional build macro: I3C_QPORT_ERR_ON_FULL_EN -- a write to a full command
// port or a read of an empty response port completes with an error instead of
// stalling the bus.
module i3c_cpuif_queue_port #(
   parameter int unsigned CsrAddrWidth = 12,
   parameter int unsigned CsrDataWidth = 32,
   parameter int unsigned CmdDepth     = 8,
   parameter int unsigned RespDepth    = 8,
   parameter logic [CsrAddrWidth-1:0] CmdPortAddr  = 'h0C0,
   parameter logic [CsrAddrWidth-1:0] RespPortAddr = 'h0C4,
   localparam int unsigned CmdFillW  = $clog2(CmdDepth + 1),
   localparam int unsigned RespFillW = $clog2(RespDepth + 1)
) (
   input  logic                    hclk_i,
   input  logic                    hreset_i,
   // upstream (bridge side)
   input  logic                    s_cpuif_req,
   input  logic                    s_cpuif_req_is_wr,
   input  logic [CsrAddrWidth-1:0] s_cpuif_addr,
   input  logic [CsrDataWidth-1:0] s_cpuif_wr_data,
   input  logic [CsrDataWidth-1:0] s_cpuif_wr_biten,
   output logic                    s_cpuif_req_stall_wr,
   output logic                    s_cpuif_req_stall_rd,
   output logic                    s_cpuif_rd_ack,
   output logic                    s_cpuif_rd_err,
   output logic [CsrDataWidth-1:0] s_cpuif_rd_data,
   output logic                    s_cpuif_wr_ack,
   output logic                    s_cpuif_wr_err,
   // downstream (register block side)
   output logic                    m_cpuif_req,
   output logic                    m_cpuif_req_is_wr,
   output logic [CsrAddrWidth-1:0] m_cpuif_addr,
   output logic [CsrDataWidth-1:0] m_cpuif_wr_data,
   output logic [CsrDataWidth-1:0] m_cpuif_wr_biten,
   input  logic                    m_cpuif_req_stall_wr,
   input  logic                    m_cpuif_req_stall_rd,
   input  logic                    m_cpuif_rd_ack,
   input  logic                    m_cpuif_rd_err,
   input  logic [CsrDataWidth-1:0] m_cpuif_rd_data,
   input  logic                    m_cpuif_wr_ack,
   input  logic                    m_cpuif_wr_err,
   // command queue head (first-word-fall-through)
   output logic                    cmd_valid_o,
   output logic [CsrDataWidth-1:0] cmd_data_o,
   input  logic                    cmd_ready_i,
   // response queue tail
   input  logic                    resp_valid_i,
   input  logic [CsrDataWidth-1:0] resp_data_i,
   output logic                    resp_ready_o,
   // occupancy
   output logic [CmdFillW-1:0]     cmd_fill_o,
   output logic [RespFillW-1:0]    resp_fill_o
);

   localparam int unsigned CmdPtrW  = $clog2(CmdDepth);
   localparam int unsigned RespPtrW = $clog2(RespDepth);
   localparam logic [CmdFillW-1:0]  CmdFull  = CmdFillW'(CmdDepth);
   localparam logic [RespFillW-1:0] RespFull = RespFillW'(RespDepth);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } state_e;

   state_e state_q, state_d;

   logic cmd_hit, resp_hit, local_hit, busy;
   logic cmd_full, resp_empty;
   logic stall_wr, stall_rd;
   logic wr_accept, rd_accept;
   logic cmd_push, cmd_pop, resp_push, resp_pop;

   logic [CsrDataWidth-1:0] cmd_mem_q  [CmdDepth];
   logic [CsrDataWidth-1:0] resp_mem_q [RespDepth];

   logic [CmdPtrW-1:0]   cmd_wptr_q, cmd_wptr_d, cmd_rptr_q, cmd_rptr_d;
   logic [RespPtrW-1:0]  resp_wptr_q, resp_wptr_d, resp_rptr_q, resp_rptr_d;
   logic [CmdFillW-1:0]  cmd_fill_q, cmd_fill_d;
   logic [RespFillW-1:0] resp_fill_q, resp_fill_d;

   logic wr_ack_q, wr_ack_d, wr_err_q, wr_err_d;
   logic rd_ack_q, rd_ack_d, rd_err_q, rd_err_d;
   logic [CsrDataWidth-1:0] rd_data_q, rd_data_d;

   // Address decode, stall generation and local acceptance (full/empty from registered fills)
   always_comb begin
      cmd_hit    = (s_cpuif_addr == CmdPortAddr);
      resp_hit   = (s_cpuif_addr == RespPortAddr);
      local_hit  = cmd_hit | resp_hit;
      busy       = (state_q == ST_ACK);
      cmd_full   = (cmd_fill_q == CmdFull);
      resp_empty = (resp_fill_q == '0);
      // A pass-through request must also wait while a local ack is pending,
      // because m_cpuif_req is held low during that cycle.
`ifdef I3C_QPORT_ERR_ON_FULL_EN
      stall_wr = local_hit ? busy : (busy | m_cpuif_req_stall_wr);
      stall_rd = local_hit ? busy : (busy | m_cpuif_req_stall_rd);
`else
      stall_wr = local_hit ? (busy | (cmd_hit & cmd_full))
                           : (busy | m_cpuif_req_stall_wr);
      stall_rd = local_hit ? (busy | (resp_hit & resp_empty))
                           : (busy | m_cpuif_req_stall_rd);
`endif
      wr_accept = s_cpuif_req &  s_cpuif_req_is_wr & local_hit & ~stall_wr;
      rd_accept = s_cpuif_req & ~s_cpuif_req_is_wr & local_hit & ~stall_rd;
      cmd_push  = wr_accept & cmd_hit & ~cmd_full;
      resp_pop  = rd_accept & resp_hit & ~resp_empty;
      cmd_pop   = cmd_valid_o & cmd_ready_i;
      resp_push = resp_valid_i & resp_ready_o;
   end

   // Next state: a local acceptance always completes in the following cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (wr_accept | rd_accept) state_d = ST_ACK;
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Completion values for a local access; any accepted access that moves no data is an error
   always_comb begin
      wr_ack_d  = wr_accept;
      wr_err_d  = wr_accept & ~cmd_push;
      rd_ack_d  = rd_accept;
      rd_err_d  = rd_accept & ~resp_pop;
      rd_data_d = resp_pop ? resp_mem_q[resp_rptr_q] : '0;
   end

   // FIFO pointer and occupancy updates; pointers wrap naturally at a power-of-two depth
   always_comb begin
      cmd_wptr_d  = cmd_wptr_q + CmdPtrW'(cmd_push);
      cmd_rptr_d  = cmd_rptr_q + CmdPtrW'(cmd_pop);
      cmd_fill_d  = cmd_fill_q + CmdFillW'(cmd_push) - CmdFillW'(cmd_pop);
      resp_wptr_d = resp_wptr_q + RespPtrW'(resp_push);
      resp_rptr_d = resp_rptr_q + RespPtrW'(resp_pop);
      resp_fill_d = resp_fill_q + RespFillW'(resp_push) - RespFillW'(resp_pop);
   end

   // Control state: FSM, pointers, fills and completion strobes
   always_ff @(posedge hclk_i or posedge hreset_i) begin
      if (hreset_i) begin
         state_q     <= ST_IDLE;
         cmd_wptr_q  <= '0;
         cmd_rptr_q  <= '0;
         cmd_fill_q  <= '0;
         resp_wptr_q <= '0;
         resp_rptr_q <= '0;
         resp_fill_q <= '0;
         wr_ack_q    <= 1'b0;
         wr_err_q    <= 1'b0;
         rd_ack_q    <= 1'b0;
         rd_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_wptr_q  <= cmd_wptr_d;
         cmd_rptr_q  <= cmd_rptr_d;
         cmd_fill_q  <= cmd_fill_d;
         resp_wptr_q <= resp_wptr_d;
         resp_rptr_q <= resp_rptr_d;
         resp_fill_q <= resp_fill_d;
         wr_ack_q    <= wr_ack_d;
         wr_err_q    <= wr_err_d;
         rd_ack_q    <= rd_ack_d;
         rd_err_q    <= rd_err_d;
      end
   end

   // Read data is only observed alongside rd_ack_q, so it needs no reset
   always_ff @(posedge hclk_i) begin
      rd_data_q <= rd_data_d;
   end

   // Queue storage is left untouched by reset; only the pointers are cleared
   always_ff @(posedge hclk_i) begin
      if (cmd_push) begin
         cmd_mem_q[cmd_wptr_q] <= s_cpuif_wr_data & s_cpuif_wr_biten;
      end
      if (resp_push) begin
         resp_mem_q[resp_wptr_q] <= resp_data_i;
      end
   end

   // Pass-through request path and upstream response mux
   always_comb begin
      m_cpuif_req          = s_cpuif_req & ~local_hit & ~busy;
      m_cpuif_req_is_wr    = s_cpuif_req_is_wr;
      m_cpuif_addr         = s_cpuif_addr;
      m_cpuif_wr_data      = s_cpuif_wr_data;
      m_cpuif_wr_biten     = s_cpuif_wr_biten;
      s_cpuif_req_stall_wr = stall_wr;
      s_cpuif_req_stall_rd = stall_rd;
      // Local and forwarded completions never coincide, so they can be merged
      s_cpuif_wr_ack       = wr_ack_q | m_cpuif_wr_ack;
      s_cpuif_wr_err       = wr_err_q | m_cpuif_wr_err;
      s_cpuif_rd_ack       = rd_ack_q | m_cpuif_rd_ack;
      s_cpuif_rd_err       = rd_err_q | m_cpuif_rd_err;
      s_cpuif_rd_data      = rd_ack_q ? rd_data_q : m_cpuif_rd_data;
   end

   // Queue-side status outputs
   always_comb begin
      cmd_valid_o  = (cmd_fill_q != '0);
      cmd_data_o   = cmd_mem_q[cmd_rptr_q];
      resp_ready_o = (resp_fill_q != RespFull);
      cmd_fill_o   = cmd_fill_q;
      resp_fill_o  = resp_fill_q;
   end

endmodule

// File: tb/tb_i3c_cpuif_queue_port.sv
// Self-checking bench for i3c_cpuif_queue_port: directed test-plan sequences
// followed by randomized traffic, checked by a queue-based reference model and
// a completion scoreboard. Honours I3C_QPORT_ERR_ON_FULL_EN when defined.
module tb_i3c_cpuif_queue_port;

   localparam logic [11:0] CMD_A  = 12'h0C0;
   localparam logic [11:0] RESP_A = 12'h0C4;
   localparam int DEPTH = 8;
`ifdef I3C_QPORT_ERR_ON_FULL_EN
   localparam bit ERR_MODE = 1'b1;
`else
   localparam bit ERR_MODE = 1'b0;
`endif

   logic        clk, hreset_i;
   logic        s_cpuif_req, s_cpuif_req_is_wr;
   logic [11:0] s_cpuif_addr;
   logic [31:0] s_cpuif_wr_data, s_cpuif_wr_biten;
   logic        s_cpuif_req_stall_wr, s_cpuif_req_stall_rd;
   logic        s_cpuif_rd_ack, s_cpuif_rd_err, s_cpuif_wr_ack, s_cpuif_wr_err;
   logic [31:0] s_cpuif_rd_data;
   logic        m_cpuif_req, m_cpuif_req_is_wr;
   logic [11:0] m_cpuif_addr;
   logic [31:0] m_cpuif_wr_data, m_cpuif_wr_biten;
   logic        m_cpuif_req_stall_wr, m_cpuif_req_stall_rd;
   logic        m_cpuif_rd_ack, m_cpuif_rd_err, m_cpuif_wr_ack, m_cpuif_wr_err;
   logic [31:0] m_cpuif_rd_data;
   logic        cmd_valid_o, cmd_ready_i, resp_valid_i, resp_ready_o;
   logic [31:0] cmd_data_o, resp_data_i;
   logic [3:0]  cmd_fill_o, resp_fill_o;

   i3c_cpuif_queue_port dut (
      .hclk_i(clk), .hreset_i(hreset_i),
      .s_cpuif_req(s_cpuif_req), .s_cpuif_req_is_wr(s_cpuif_req_is_wr),
      .s_cpuif_addr(s_cpuif_addr), .s_cpuif_wr_data(s_cpuif_wr_data),
      .s_cpuif_wr_biten(s_cpuif_wr_biten),
      .s_cpuif_req_stall_wr(s_cpuif_req_stall_wr), .s_cpuif_req_stall_rd(s_cpuif_req_stall_rd),
      .s_cpuif_rd_ack(s_cpuif_rd_ack), .s_cpuif_rd_err(s_cpuif_rd_err),
      .s_cpuif_rd_data(s_cpuif_rd_data), .s_cpuif_wr_ack(s_cpuif_wr_ack),
      .s_cpuif_wr_err(s_cpuif_wr_err),
      .m_cpuif_req(m_cpuif_req), .m_cpuif_req_is_wr(m_cpuif_req_is_wr),
      .m_cpuif_addr(m_cpuif_addr), .m_cpuif_wr_data(m_cpuif_wr_data),
      .m_cpuif_wr_biten(m_cpuif_wr_biten),
      .m_cpuif_req_stall_wr(m_cpuif_req_stall_wr), .m_cpuif_req_stall_rd(m_cpuif_req_stall_rd),
      .m_cpuif_rd_ack(m_cpuif_rd_ack), .m_cpuif_rd_err(m_cpuif_rd_err),
      .m_cpuif_rd_data(m_cpuif_rd_data), .m_cpuif_wr_ack(m_cpuif_wr_ack),
      .m_cpuif_wr_err(m_cpuif_wr_err),
      .cmd_valid_o(cmd_valid_o), .cmd_data_o(cmd_data_o), .cmd_ready_i(cmd_ready_i),
      .resp_valid_i(resp_valid_i), .resp_data_i(resp_data_i), .resp_ready_o(resp_ready_o),
      .cmd_fill_o(cmd_fill_o), .resp_fill_o(resp_fill_o)
   );

   typedef struct {
      bit          is_wr;
      bit          err;
      logic [31:0] data;
      int          due;
   } exp_t;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   exp_t        sb[$];
   logic [31:0] cmd_m[$];
   logic [31:0] resp_m[$];
   bit          busy_m;

   // register-block responder state (set by the model, driven by the stimulus process)
   bit          pend_v, pend_wr, pend_err;
   logic [31:0] pend_data;

   bit rand_fifo;
   int ready_pct, valid_pct, mstall_pct;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // FIFO-side and register-block-side stimulus, updated just after each rising edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_fifo) begin
            cmd_ready_i  = ($urandom_range(0, 99) < ready_pct);
            resp_valid_i = ($urandom_range(0, 99) < valid_pct);
            resp_data_i  = $urandom;
         end
         m_cpuif_req_stall_wr = ($urandom_range(0, 99) < mstall_pct);
         m_cpuif_req_stall_rd = ($urandom_range(0, 99) < mstall_pct);
         m_cpuif_wr_ack  = pend_v & pend_wr;
         m_cpuif_wr_err  = pend_v & pend_wr & pend_err;
         m_cpuif_rd_ack  = pend_v & ~pend_wr;
         m_cpuif_rd_err  = pend_v & ~pend_wr & pend_err;
         m_cpuif_rd_data = (pend_v && !pend_wr) ? pend_data : 32'h0;
         pend_v = 1'b0;
      end
   end

   // Reference model: queues + busy flag, evaluated on the falling edge
   bit          md_req, md_wr, md_ch, md_rh, md_lc, md_sw, md_sr, md_acc, md_push;
   int          md_nc, md_nr;
   logic [31:0] md_pv;
   exp_t        md_e;

   initial begin
      busy_m = 1'b0;
      forever begin
         @(negedge clk);
         if (hreset_i) begin
            cmd_m.delete();
            resp_m.delete();
            busy_m = 1'b0;
            pend_v = 1'b0;
            chk("rst_acks", 128'({s_cpuif_wr_ack, s_cpuif_wr_err, s_cpuif_rd_ack, s_cpuif_rd_err}), 128'(0));
            chk("rst_stalls", 128'({s_cpuif_req_stall_wr, s_cpuif_req_stall_rd, m_cpuif_req}), 128'(0));
            chk("rst_rd_data", 128'(s_cpuif_rd_data), 128'(0));
            chk("rst_fifo", 128'({cmd_valid_o, resp_ready_o, cmd_fill_o, resp_fill_o}), 128'(10'b01_0000_0000));
         end else begin
            md_req = s_cpuif_req;
            md_wr  = s_cpuif_req_is_wr;
            md_ch  = (s_cpuif_addr == CMD_A);
            md_rh  = (s_cpuif_addr == RESP_A);
            md_lc  = md_ch || md_rh;
            md_nc  = cmd_m.size();
            md_nr  = resp_m.size();
            if (md_lc) begin
               md_sw = busy_m || (md_ch && md_nc == DEPTH && !ERR_MODE);
               md_sr = busy_m || (md_rh && md_nr == 0 && !ERR_MODE);
            end else begin
               md_sw = busy_m || m_cpuif_req_stall_wr;
               md_sr = busy_m || m_cpuif_req_stall_rd;
            end
            chk("stall_wr", 128'(s_cpuif_req_stall_wr), 128'(md_sw));
            chk("stall_rd", 128'(s_cpuif_req_stall_rd), 128'(md_sr));
            chk("m_fwd",
                128'({m_cpuif_req, m_cpuif_req_is_wr, m_cpuif_addr, m_cpuif_wr_data, m_cpuif_wr_biten}),
                128'({md_req && !md_lc && !busy_m, s_cpuif_req_is_wr, s_cpuif_addr,
                      s_cpuif_wr_data, s_cpuif_wr_biten}));
            chk("cmd_fill", 128'(cmd_fill_o), 128'(md_nc));
            chk("cmd_valid", 128'(cmd_valid_o), 128'(md_nc != 0));
            if (md_nc != 0) chk("cmd_data", 128'(cmd_data_o), 128'(cmd_m[0]));
            chk("resp_fill", 128'(resp_fill_o), 128'(md_nr));
            chk("resp_ready", 128'(resp_ready_o), 128'(md_nr != DEPTH));

            md_acc  = md_req && !(md_wr ? md_sw : md_sr);
            md_push = 1'b0;
            md_pv   = 32'h0;
            if (md_acc && md_lc) begin
               md_e.is_wr = md_wr;
               md_e.err   = 1'b1;
               md_e.data  = 32'h0;
               md_e.due   = cyc + 1;
               if (md_wr && md_ch && md_nc < DEPTH) begin
                  md_push  = 1'b1;
                  md_pv    = s_cpuif_wr_data & s_cpuif_wr_biten;
                  md_e.err = 1'b0;
               end else if (!md_wr && md_rh && md_nr > 0) begin
                  md_e.data = resp_m.pop_front();
                  md_e.err  = 1'b0;
               end
               sb.push_back(md_e);
            end else if (md_acc) begin
               pend_v     = 1'b1;
               pend_wr    = md_wr;
               pend_err   = ($urandom_range(0, 1) == 1);
               pend_data  = $urandom;
               md_e.is_wr = md_wr;
               md_e.err   = pend_err;
               md_e.data  = md_wr ? 32'h0 : pend_data;
               md_e.due   = cyc + 1;
               sb.push_back(md_e);
            end
            if (cmd_ready_i && md_nc > 0) void'(cmd_m.pop_front());
            if (md_push) cmd_m.push_back(md_pv);
            if (resp_valid_i && md_nr < DEPTH) resp_m.push_back(resp_data_i);
            busy_m = md_acc && md_lc;
         end
      end
   end

   // Completion monitor: every ack must match the oldest expected completion in its cycle
   exp_t mon_e;
   initial begin
      forever begin
         @(negedge clk);
         if (hreset_i) begin
            sb.delete();
         end else if (s_cpuif_wr_ack || s_cpuif_rd_ack) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack cycle %0d: wr_ack %0b rd_ack %0b with nothing expected",
                        cyc, s_cpuif_wr_ack, s_cpuif_rd_ack);
            end else begin
               mon_e = sb.pop_front();
               chk("ack_kind", 128'({s_cpuif_wr_ack, s_cpuif_rd_ack}), 128'(mon_e.is_wr ? 2'b10 : 2'b01));
               chk("ack_cycle", 128'(cyc), 128'(mon_e.due));
               chk("ack_err", 128'({s_cpuif_wr_err, s_cpuif_rd_err}),
                   128'(mon_e.is_wr ? {mon_e.err, 1'b0} : {1'b0, mon_e.err}));
               if (!mon_e.is_wr) chk("rd_data", 128'(s_cpuif_rd_data), 128'(mon_e.data));
            end
         end else begin
            chk("err_without_ack", 128'({s_cpuif_wr_err, s_cpuif_rd_err}), 128'(0));
            if (sb.size() > 0 && sb[0].due <= cyc) begin
               checks++;
               errors++;
               $display("FAIL missing_ack cycle %0d: got no ack, expected one due at cycle %0d",
                        cyc, sb[0].due);
               void'(sb.pop_front());
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one request and hold it until the DUT accepts it (bounded)
   task automatic do_txn(input bit wr, input logic [11:0] a, input logic [31:0] d,
                         input logic [31:0] be);
      int n;
      s_cpuif_req       = 1'b1;
      s_cpuif_req_is_wr = wr;
      s_cpuif_addr      = a;
      s_cpuif_wr_data   = d;
      s_cpuif_wr_biten  = be;
      n = 0;
      forever begin
         @(negedge clk);
         if (!(wr ? s_cpuif_req_stall_wr : s_cpuif_req_stall_rd)) break;
         n++;
         if (n > 1000) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout addr %0h wr %0b: still stalled after %0d cycles", a, wr, n);
            break;
         end
      end
      @(posedge clk);
      #1;
      s_cpuif_req = 1'b0;
   endtask

   logic [11:0] r_addr;
   bit          r_wr;
   int          r_sel;

   initial begin
      hreset_i = 1'b1;
      s_cpuif_req = 1'b0; s_cpuif_req_is_wr = 1'b0; s_cpuif_addr = 12'h0;
      s_cpuif_wr_data = 32'h0; s_cpuif_wr_biten = 32'h0;
      cmd_ready_i = 1'b0; resp_valid_i = 1'b0; resp_data_i = 32'h0;
      m_cpuif_req_stall_wr = 1'b0; m_cpuif_req_stall_rd = 1'b0;
      m_cpuif_rd_ack = 1'b0; m_cpuif_rd_err = 1'b0; m_cpuif_rd_data = 32'h0;
      m_cpuif_wr_ack = 1'b0; m_cpuif_wr_err = 1'b0;
      pend_v = 1'b0; pend_wr = 1'b0; pend_err = 1'b0; pend_data = 32'h0;
      rand_fifo = 1'b0; ready_pct = 0; valid_pct = 0; mstall_pct = 0;
      idle(3);
      hreset_i = 1'b0;

      // first command, then fill to eight and a ninth that waits for one pop
      do_txn(1'b1, CMD_A, 32'hA5A5_0001, 32'hFFFF_FFFF);
      idle(2);
      for (int i = 0; i < 7; i++) do_txn(1'b1, CMD_A, $urandom, (i % 2 == 0) ? 32'hFFFF_FFFF : $urandom);
      fork
         do_txn(1'b1, CMD_A, 32'h9999_0009, 32'hFFFF_FFFF);
         begin
            idle(4);
            cmd_ready_i = 1'b1;
            idle(1);
            cmd_ready_i = 1'b0;
         end
      join
      idle(3);
      cmd_ready_i = 1'b1;
      idle(10);
      cmd_ready_i = 1'b0;

      // response path: one word, then a read with the queue empty
      resp_valid_i = 1'b1; resp_data_i = 32'h0000_1234;
      idle(1);
      resp_valid_i = 1'b0;
      do_txn(1'b0, RESP_A, 32'h0, 32'h0);
      idle(1);
      fork
         do_txn(1'b0, RESP_A, 32'h0, 32'h0);
         begin
            idle(3);
            resp_valid_i = 1'b1; resp_data_i = 32'hBEEF_0002;
            idle(1);
            resp_valid_i = 1'b0;
         end
      join
      idle(2);

      // wrong-direction accesses
      do_txn(1'b0, CMD_A, 32'h0, 32'h0);
      do_txn(1'b1, RESP_A, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
      idle(1);

      // pass-through to the register block with a stalling responder
      mstall_pct = 50;
      do_txn(1'b1, 12'h100, 32'h0102_0304, 32'hFFFF_FFFF);
      do_txn(1'b0, 12'h100, 32'h0, 32'h0);
      idle(2);

      // randomized traffic
      rand_fifo  = 1'b1;
      mstall_pct = 20;
      for (int i = 0; i < 600; i++) begin
         if (i == 0)   begin ready_pct = 15; valid_pct = 60; end
         if (i == 300) begin ready_pct = 70; valid_pct = 15; end
         r_sel = $urandom_range(0, 99);
         if (r_sel < 40) begin
            r_addr = CMD_A;
            r_wr   = ($urandom_range(0, 9) != 0);
         end else if (r_sel < 75) begin
            r_addr = RESP_A;
            r_wr   = ($urandom_range(0, 9) == 0);
         end else begin
            r_addr = 12'h100 + 12'($urandom_range(0, 15) * 4);
            r_wr   = ($urandom_range(0, 1) == 1);
         end
         do_txn(r_wr, r_addr, $urandom, ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom);
         idle($urandom_range(0, 1));
      end

      // reset during the ack cycle of a command write
      rand_fifo = 1'b0;
      mstall_pct = 0;
      resp_valid_i = 1'b0;
      cmd_ready_i = 1'b1;
      idle(12);
      cmd_ready_i = 1'b0;
      idle(2);
      do_txn(1'b1, CMD_A, 32'h5555_AAAA, 32'hFFFF_FFFF);
      hreset_i = 1'b1;
      s_cpuif_addr = 12'h0;
      idle(2);
      hreset_i = 1'b0;
      idle(4);
      chk("sb_drained", 128'(sb.size()), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
